mem_bus_arbiter: RTL and testbench

//  Shares the single 16-bit address / 8-bit data memory bus between the CPU (default owner) and one secondary

---
 rtl/mem_bus_arbiter.sv | 117 +++++++++++
 tb/tb_mem_bus_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Memory bus arbiter: CPU is default owner, one secondary master may take the bus on CPU read cycles.
// Optional burst limit with a CPU gap after a forced release is enabled by defining ARB_BURST_LIMIT_EN.
module mem_bus_arbiter #(
  parameter int MAX_BURST = 16,
  parameter int CPU_GAP   = 4,
  parameter int CNT_W     = 8
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic [15:0] cpu_adr,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_rw,
  output logic        cpu_en,
  output logic [7:0]  cpu_din,
  input  logic        dma_req,
  output logic        dma_gnt,
  input  logic [15:0] dma_adr,
  input  logic [7:0]  dma_dout,
  input  logic        dma_rw,
  output logic [7:0]  dma_din,
  output logic [15:0] mem_adr,
  output logic [7:0]  mem_dout,
  output logic        mem_rw,
  input  logic [7:0]  mem_din,
  output logic [1:0]  arb_state
);

  // Handshake: dma_req is a level held while the bus is wanted; dma_gnt high means the DMA bus
  // inputs drive memory this cycle. Ownership changes only through HALT and RETURN.
  typedef enum logic [1:0] {CPU_OWN, HALT, DMA_OWN, RETURN} state_t;

  localparam bit CFG_OK = (MAX_BURST >= 1) && (MAX_BURST < 2**CNT_W) && (CPU_GAP < 2**CNT_W);
  generate
    if (!CFG_OK) begin : g_cfg_check
      $error("mem_bus_arbiter: CNT_W too small for MAX_BURST/CPU_GAP");
    end
  endgenerate

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             gap_pend, gap_pend_nxt;
  logic             gap_done;
  logic             sel_dma, force_rd;

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    gap_pend_nxt = gap_pend;
    gap_done     = 1'b1;
    case (state)
      CPU_OWN: begin
`ifdef ARB_BURST_LIMIT_EN
        // The gap counts CPU_OWN cycles after a forced release; the last one may already start HALT.
        if (gap_pend) begin
          gap_done = (int'(cnt) + 1 >= CPU_GAP);
          if (cnt != '1) cnt_nxt = cnt + CNT_W'(1);
          if (gap_done) gap_pend_nxt = 1'b0;
        end
`endif
        if (dma_req && cpu_rw && gap_done) state_nxt = HALT;
      end
      HALT: begin
        if (dma_req) begin
          state_nxt = DMA_OWN;
          cnt_nxt   = '0;
        end else begin
          state_nxt = RETURN;
        end
      end
      DMA_OWN: begin
        if (cnt != '1) cnt_nxt = cnt + CNT_W'(1);
        if (!dma_req) begin
          state_nxt = RETURN;
        end
`ifdef ARB_BURST_LIMIT_EN
        else if (int'(cnt) == MAX_BURST - 1) begin
          state_nxt    = RETURN;
          cnt_nxt      = '0;
          gap_pend_nxt = 1'b1;
        end
`endif
      end
      RETURN:  state_nxt = CPU_OWN;
      default: state_nxt = CPU_OWN;
    endcase
  end

  // All bus-facing controls are registered from the next state, so nothing combinational
  // runs from dma_req to dma_gnt or cpu_en.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state    <= CPU_OWN;
      cnt      <= '0;
      gap_pend <= 1'b0;
      cpu_en   <= 1'b1;
      dma_gnt  <= 1'b0;
      sel_dma  <= 1'b0;
      force_rd <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      gap_pend <= gap_pend_nxt;
      cpu_en   <= (state_nxt == CPU_OWN);
      dma_gnt  <= (state_nxt == DMA_OWN);
      sel_dma  <= (state_nxt == DMA_OWN);
      force_rd <= (state_nxt == HALT) || (state_nxt == RETURN);
    end
  end

  assign mem_adr   = sel_dma ? dma_adr  : cpu_adr;
  assign mem_dout  = sel_dma ? dma_dout : cpu_dout;
  assign mem_rw    = sel_dma ? dma_rw   : (cpu_rw | force_rd);
  assign cpu_din   = mem_din;
  assign dma_din   = mem_din;
  assign arb_state = state;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed vector table, burst/reset sequences,
// and randomized traffic against an ownership-level reference model.
module tb_mem_bus_arbiter;

  localparam int MAX_BURST = 16;
  localparam int CPU_GAP   = 4;
`ifdef ARB_BURST_LIMIT_EN
  localparam bit LIMIT = 1'b1;
`else
  localparam bit LIMIT = 1'b0;
`endif

  logic        clk, n_reset;
  logic [15:0] cpu_adr, dma_adr, mem_adr;
  logic [7:0]  cpu_dout, cpu_din, dma_dout, dma_din, mem_dout, mem_din;
  logic        cpu_rw, cpu_en, dma_req, dma_gnt, dma_rw, mem_rw;
  logic [1:0]  arb_state;

  mem_bus_arbiter #(.MAX_BURST(MAX_BURST), .CPU_GAP(CPU_GAP), .CNT_W(8)) dut (
    .clk(clk), .n_reset(n_reset),
    .cpu_adr(cpu_adr), .cpu_dout(cpu_dout), .cpu_rw(cpu_rw), .cpu_en(cpu_en), .cpu_din(cpu_din),
    .dma_req(dma_req), .dma_gnt(dma_gnt), .dma_adr(dma_adr), .dma_dout(dma_dout), .dma_rw(dma_rw),
    .dma_din(dma_din), .mem_adr(mem_adr), .mem_dout(mem_dout), .mem_rw(mem_rw), .mem_din(mem_din),
    .arb_state(arb_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the bus, whether a handover is in progress, burst length and gap.
  bit m_dma;     // DMA currently drives the bus
  int m_ho;      // 0 none, 1 taking bus from CPU, 2 giving bus back to CPU
  int m_burst;   // DMA cycles completed in current burst
  int m_gap;     // CPU cycles still owed before the next takeover (counting the current one)

  task automatic model_step(input bit rst_n, input bit req, input bit crw);
    if (!rst_n) begin
      m_dma = 0; m_ho = 0; m_burst = 0; m_gap = 0;
    end else if (m_ho == 1) begin
      if (req) begin m_dma = 1; m_burst = 0; m_ho = 0; end
      else m_ho = 2;
    end else if (m_ho == 2) begin
      m_ho = 0;
    end else if (m_dma) begin
      m_burst++;
      if (!req) begin
        m_dma = 0; m_ho = 2;
      end else if (LIMIT && m_burst == MAX_BURST) begin
        m_dma = 0; m_ho = 2; m_gap = CPU_GAP;
      end
    end else begin
      if (req && crw && m_gap <= 1) m_ho = 1;
      if (m_gap > 0) m_gap--;
    end
  endtask

  task automatic check_model();
    logic        e_en, e_gnt, e_rw;
    logic [15:0] e_adr;
    logic [7:0]  e_dout;
    e_gnt  = m_dma;
    e_en   = !m_dma && (m_ho == 0);
    e_adr  = m_dma ? dma_adr : cpu_adr;
    e_dout = m_dma ? dma_dout : cpu_dout;
    e_rw   = m_dma ? dma_rw : ((m_ho != 0) ? 1'b1 : cpu_rw);
    check("rnd_cpu_en",   16'(cpu_en),   16'(e_en));
    check("rnd_dma_gnt",  16'(dma_gnt),  16'(e_gnt));
    check("rnd_mem_adr",  mem_adr,       e_adr);
    check("rnd_mem_dout", 16'(mem_dout), 16'(e_dout));
    check("rnd_mem_rw",   16'(mem_rw),   16'(e_rw));
    check("rnd_cpu_din",  16'(cpu_din),  16'(mem_din));
    check("rnd_dma_din",  16'(dma_din),  16'(mem_din));
  endtask

  // driver: advance one clock, stepping the model with the inputs seen at the posedge
  task automatic tick();
    @(posedge clk);
    model_step(n_reset, dma_req, cpu_rw);
    @(negedge clk);
  endtask

  typedef struct {
    bit          req, crw, drw;
    logic [15:0] dadr;
    bit          e_en, e_gnt, e_rw;
    logic [15:0] e_adr;
    logic [7:0]  e_dout;
  } vec_t;

  vec_t vecs[16];

  initial begin
    // req, crw, drw, dma_adr | cpu_en, dma_gnt, mem_rw, mem_adr, mem_dout
    vecs[0]  = '{1, 1, 1, 16'h0200, 1, 0, 1, 16'h0100, 8'h3C};  // CPU read, request seen
    vecs[1]  = '{1, 0, 1, 16'h0200, 0, 0, 1, 16'h0100, 8'h3C};  // HALT forces read
    vecs[2]  = '{1, 1, 1, 16'h0200, 0, 1, 1, 16'h0200, 8'hA5};  // DMA read
    vecs[3]  = '{1, 1, 0, 16'h0300, 0, 1, 0, 16'h0300, 8'hA5};  // DMA write
    vecs[4]  = '{0, 0, 0, 16'h0300, 0, 1, 0, 16'h0300, 8'hA5};  // req drop, still DMA
    vecs[5]  = '{0, 0, 0, 16'h0300, 0, 0, 1, 16'h0100, 8'h3C};  // RETURN forces read
    vecs[6]  = '{1, 0, 1, 16'h0200, 1, 0, 0, 16'h0100, 8'h3C};  // CPU write not interrupted
    vecs[7]  = '{1, 0, 1, 16'h0200, 1, 0, 0, 16'h0100, 8'h3C};
    vecs[8]  = '{1, 0, 1, 16'h0200, 1, 0, 0, 16'h0100, 8'h3C};
    vecs[9]  = '{1, 1, 1, 16'h0200, 1, 0, 1, 16'h0100, 8'h3C};  // first read -> HALT
    vecs[10] = '{0, 1, 1, 16'h0200, 0, 0, 1, 16'h0100, 8'h3C};  // withdrawn in HALT
    vecs[11] = '{1, 1, 1, 16'h0200, 0, 0, 1, 16'h0100, 8'h3C};  // RETURN ignores req
    vecs[12] = '{1, 1, 1, 16'h0200, 1, 0, 1, 16'h0100, 8'h3C};
    vecs[13] = '{0, 0, 1, 16'h0200, 0, 0, 1, 16'h0100, 8'h3C};  // HALT, req gone
    vecs[14] = '{0, 1, 1, 16'h0200, 0, 0, 1, 16'h0100, 8'h3C};  // RETURN
    vecs[15] = '{0, 0, 1, 16'h0200, 1, 0, 0, 16'h0100, 8'h3C};  // CPU again
  end

  initial begin
    int run, gap_len, phase;
    bit got;

    n_reset = 0; dma_req = 0; cpu_rw = 1; dma_rw = 1;
    cpu_adr = 16'h0100; cpu_dout = 8'h3C; dma_adr = 16'h0200; dma_dout = 8'hA5; mem_din = 8'h5A;
    m_dma = 0; m_ho = 0; m_burst = 0; m_gap = 0;

    // reset held two cycles
    @(negedge clk);
    tick();
    tick();
    cpu_rw = 0;
    #1;
    check("rst_cpu_en",  16'(cpu_en),  16'd1);
    check("rst_dma_gnt", 16'(dma_gnt), 16'd0);
    check("rst_mem_adr", mem_adr,      16'h0100);
    check("rst_mem_rw0", 16'(mem_rw),  16'd0);
    cpu_rw = 1;
    #1;
    check("rst_mem_rw1", 16'(mem_rw),  16'd1);
    n_reset = 1;

    // directed vector table
    for (int i = 0; i < 16; i++) begin
      dma_req = vecs[i].req; cpu_rw = vecs[i].crw; dma_rw = vecs[i].drw; dma_adr = vecs[i].dadr;
      #1;
      check($sformatf("vec%0d_cpu_en", i),   16'(cpu_en),   16'(vecs[i].e_en));
      check($sformatf("vec%0d_dma_gnt", i),  16'(dma_gnt),  16'(vecs[i].e_gnt));
      check($sformatf("vec%0d_mem_rw", i),   16'(mem_rw),   16'(vecs[i].e_rw));
      check($sformatf("vec%0d_mem_adr", i),  mem_adr,       vecs[i].e_adr);
      check($sformatf("vec%0d_mem_dout", i), 16'(mem_dout), 16'(vecs[i].e_dout));
      tick();
    end

    // held request: measure first grant run and the low gap that follows
    dma_req = 0; dma_rw = 1; cpu_rw = 1;
    n_reset = 0; tick(); n_reset = 1;
    dma_req = 1;
    run = 0; gap_len = 0; phase = 0;
    for (int c = 0; c < 130; c++) begin
      #1;
      if (phase == 0 && dma_gnt) phase = 1;
      if (phase == 1) begin
        if (dma_gnt) run++;
        else begin phase = 2; gap_len = 1; end
      end else if (phase == 2) begin
        if (dma_gnt) phase = 3;
        else gap_len++;
      end
      tick();
    end
`ifdef ARB_BURST_LIMIT_EN
    check("burst_len",  16'(run),     16'(MAX_BURST));
    check("burst_gap",  16'(gap_len), 16'(CPU_GAP + 2));
`else
    check("burst_unlimited", 16'(run >= 100), 16'd1);
`endif

    // reset while DMA owns the bus
    dma_req = 0; n_reset = 0; tick(); n_reset = 1;
    dma_req = 1; cpu_rw = 1; dma_adr = 16'h0400;
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      tick();
      #1;
      got = dma_gnt;
    end
    check("dma_reached", 16'(got), 16'd1);
    n_reset = 0;
    tick();
    #1;
    check("rst_dma_gnt_drop", 16'(dma_gnt), 16'd0);
    check("rst_dma_cpu_en",   16'(cpu_en),  16'd1);
    check("rst_dma_mux",      mem_adr,      16'h0100);
    n_reset = 1;
    tick();
    #1;
    check("post_rst_halt_en", 16'(cpu_en), 16'd0);

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      n_reset  = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 7) == 0) dma_req = ~dma_req;
      cpu_rw   = $urandom_range(0, 1);
      dma_rw   = $urandom_range(0, 1);
      cpu_adr  = 16'($urandom);
      dma_adr  = 16'($urandom);
      cpu_dout = 8'($urandom);
      dma_dout = 8'($urandom);
      mem_din  = 8'($urandom);
      #1;
      check_model();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
